// File: rtl/exec_ctrl_pkg.sv
// ============================================================================
// Module : exec_ctrl_pkg
// Brief  : Shared state encoding and counter-width default for exec_controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package exec_ctrl_pkg;

  localparam int CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    BRK  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module : sync_edge
// Brief  : Multi-flop synchroniser followed by a rising-edge detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_sync <= '0;
        else       r_sync <= {r_sync[STAGES-2:0], din};
      end
    end
  endgenerate

  assign level = r_sync[STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= level;
  end

  assign rise = level & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/exec_controller.sv
// ============================================================================
// Module : exec_controller
// Brief  : Run/halt/single-step execution controller with retired counter.
//          Optional breakpoint stop enabled by macro BREAKPOINT_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exec_controller
  import exec_ctrl_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic [4:0]       sel_addr,
  input  logic [4:0]       instr_rs,
  input  logic             cpu_regwrite,
  input  logic [7:0]       pc,
  input  logic [7:0]       bp_addr,
  output logic             cpu_en,
  output logic [4:0]       rf_read_addr,
  output logic             rf_write_en,
  output logic             disp_src,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_next;
  logic   w_run;
  logic   w_step_pulse;
  logic   w_bp_hit;
  logic   w_unused_run_rise;
  logic   w_unused_step_level;

  sync_edge #(.STAGES(SYNC_STAGES)) u_run_sync (
    .clk   (clk),
    .reset (reset),
    .din   (run_sw),
    .level (w_run),
    .rise  (w_unused_run_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (step_btn),
    .level (w_unused_step_level),
    .rise  (w_step_pulse)
  );

`ifdef BREAKPOINT_EN
  assign w_bp_hit = (pc == bp_addr);
`else
  logic w_unused_bp;
  assign w_bp_hit    = 1'b0;
  assign w_unused_bp = ^{pc, bp_addr};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= HALT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    cpu_en       = 1'b0;
    rf_read_addr = sel_addr;
    disp_src     = 1'b0;
    case (r_state)
      HALT: begin
        if (w_run)             w_next = RUN;
        else if (w_step_pulse) w_next = STEP;
      end
      RUN: begin
        rf_read_addr = instr_rs;
        disp_src     = 1'b1;
        // A breakpoint hit swallows the tick; otherwise a tick in the
        // same cycle as run_sw dropping still advances the processor.
        if (tick && w_bp_hit) begin
          w_next = BRK;
        end else begin
          cpu_en = tick;
          if (!w_run) w_next = HALT;
        end
      end
      STEP: begin
        cpu_en       = 1'b1;
        rf_read_addr = instr_rs;
        disp_src     = 1'b1;
        w_next       = HALT;
      end
      BRK: begin
        if (!w_run)            w_next = HALT;
        else if (w_step_pulse) w_next = STEP;
      end
      default: w_next = HALT;
    endcase
  end

  assign rf_write_en = cpu_regwrite & cpu_en;
  assign state       = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       retired <= '0;
    else if (cpu_en) retired <= retired + C_ONE;
  end

endmodule

`default_nettype wire
